// File: rtl/des_key_scheduler.sv
// des_key_scheduler: sequential DES key schedule.
// Takes one 64-bit key and emits the 16 48-bit round subkeys in order, one per
// valid/ready handshake, tagged with the emission index.
// Optional feature macro: DES_DECRYPT_EN. When defined, the scheduler samples
// 'decrypt' at key accept and can emit K16..K1 using right rotations.
module des_key_scheduler (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] key,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic        decrypt,
    output logic [47:0] subkey,
    output logic [3:0]  subkey_round,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        sched_done
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // Bit i set when round i rotates by two positions (1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1)
    localparam logic [15:0] SHIFT2 = 16'h7EFC;

    // Permuted choice 1: FIPS bit numbers, bit 1 = key[63]
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // Permuted choice 2: FIPS bit numbers over {C,D}, bit 1 = cd[55]
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = k[6'(64 - PC1[i])];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[6'(47 - i)] = cd[6'(56 - PC2[i])];
        end
        return r;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] h, input logic two);
        return two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
    endfunction

`ifdef DES_DECRYPT_EN
    function automatic logic [27:0] rotr(input logic [27:0] h, input logic two);
        return two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
    endfunction
`endif

    logic        state;
    logic [27:0] c, d;
    logic [27:0] nc, nd;
    logic [55:0] cd0;
    logic [47:0] next_sk;

`ifdef DES_DECRYPT_EN
    logic        dec_q;
`else
    // decrypt has no effect in this build; tie it off explicitly
    logic        unused_decrypt;
    assign unused_decrypt = decrypt;
`endif

    // Parity bits (FIPS 8,16,...,64) never enter the schedule
    logic unused_parity;
    assign unused_parity = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8],  key[0]};

    assign key_ready    = (state == ST_IDLE) && !reset;
    assign subkey_valid = (state == ST_RUN);

    // Next C/D: first rotation from PC-1 on accept, per-round rotation while running
    always_comb begin
        cd0 = pc1(key);
        nc  = c;
        nd  = d;
        if (state == ST_IDLE) begin
`ifdef DES_DECRYPT_EN
            if (decrypt) begin
                // K16 uses C16/D16, which equal C0/D0 after the full 28-bit rotation
                nc = cd0[55:28];
                nd = cd0[27:0];
            end else begin
                nc = rotl(cd0[55:28], 1'b0);
                nd = rotl(cd0[27:0], 1'b0);
            end
`else
            nc = rotl(cd0[55:28], 1'b0);
            nd = rotl(cd0[27:0], 1'b0);
`endif
        end else begin
`ifdef DES_DECRYPT_EN
            if (dec_q) begin
                // Undo the shift of round 15-r to step from K(16-r) to K(15-r)
                nc = rotr(c, SHIFT2[~subkey_round]);
                nd = rotr(d, SHIFT2[~subkey_round]);
            end else begin
                nc = rotl(c, SHIFT2[subkey_round + 4'd1]);
                nd = rotl(d, SHIFT2[subkey_round + 4'd1]);
            end
`else
            nc = rotl(c, SHIFT2[subkey_round + 4'd1]);
            nd = rotl(d, SHIFT2[subkey_round + 4'd1]);
`endif
        end
        next_sk = pc2({nc, nd});
    end

    // Control FSM plus C/D and subkey registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            c            <= '0;
            d            <= '0;
            subkey       <= '0;
            subkey_round <= '0;
            sched_done   <= 1'b0;
`ifdef DES_DECRYPT_EN
            dec_q        <= 1'b0;
`endif
        end else begin
            sched_done <= 1'b0;
            if (state == ST_IDLE) begin
                if (key_valid && key_ready) begin
                    c            <= nc;
                    d            <= nd;
                    subkey       <= next_sk;
                    subkey_round <= '0;
                    state        <= ST_RUN;
`ifdef DES_DECRYPT_EN
                    dec_q        <= decrypt;
`endif
                end
            end else if (subkey_ready) begin
                if (subkey_round == 4'd15) begin
                    // Last subkey consumed: subkey keeps its value, C/D untouched
                    state        <= ST_IDLE;
                    subkey_round <= '0;
                    sched_done   <= 1'b1;
                end else begin
                    c            <= nc;
                    d            <= nd;
                    subkey       <= next_sk;
                    subkey_round <= subkey_round + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_des_key_scheduler.sv
// Self-checking bench for des_key_scheduler: table-driven schedules plus
// hand-written reset and back-to-back key sequences, scoreboard-checked.
module tb_des_key_scheduler;

    logic        clock;
    logic        reset;
    logic [63:0] key;
    logic        key_valid;
    logic        key_ready;
    logic        decrypt;
    logic [47:0] subkey;
    logic [3:0]  subkey_round;
    logic        subkey_valid;
    logic        subkey_ready;
    logic        sched_done;

    des_key_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .key         (key),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .decrypt     (decrypt),
        .subkey      (subkey),
        .subkey_round(subkey_round),
        .subkey_valid(subkey_valid),
        .subkey_ready(subkey_ready),
        .sched_done  (sched_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [63:0] K0 = 64'h133457799BBCDFF1;

    // Published K1..K16 for K0; the complemented key yields complemented subkeys
    localparam logic [47:0] KTAB [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    typedef struct {
        logic [47:0] sk;
        logic [3:0]  rd;
    } exp_t;

    typedef struct {
        bit inv;    // use complemented key
        bit dec;    // decrypt request
        bit rnd;    // random subkey_ready
        bit pulse;  // toggle key_valid with a stray key during RUN
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] exp_sub(input bit inv, input bit dec, input int r);
        int idx;
        idx = r;
`ifdef DES_DECRYPT_EN
        if (dec) idx = 15 - r;
`endif
        return inv ? ~KTAB[idx] : KTAB[idx];
    endfunction

    task automatic push_sched(input bit inv, input bit dec);
        exp_t e;
        for (int r = 0; r < 16; r++) begin
            e.sk = exp_sub(inv, dec, r);
            e.rd = 4'(r);
            sb.push_back(e);
        end
    endtask

    // Monitor: scoreboard pops on handshakes, hold stability, done pulse, ready/valid
    logic [47:0] hold_sk;
    logic [3:0]  hold_rd;
    bit          hold_chk  = 0;
    bit          done_pend = 0;
    always @(negedge clock) begin
        if (reset) begin
            hold_chk  = 0;
            done_pend = 0;
        end else begin
            check("sched_done", {63'd0, sched_done}, {63'd0, done_pend});
            check("key_ready_vs_valid", {63'd0, key_ready}, {63'd0, !subkey_valid});
            if (hold_chk) begin
                check("hold_valid", {63'd0, subkey_valid}, 64'd1);
                check("hold_subkey", {16'd0, subkey}, {16'd0, hold_sk});
                check("hold_round", {60'd0, subkey_round}, {60'd0, hold_rd});
            end
            done_pend = 0;
            hold_chk  = 0;
            if (subkey_valid && subkey_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_subkey", {16'd0, subkey}, 64'hDEAD_BEEF_0000);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_subkey", {16'd0, subkey}, {16'd0, e.sk});
                    check("sb_round", {60'd0, subkey_round}, {60'd0, e.rd});
                end
                done_pend = (subkey_round == 4'd15);
            end else if (subkey_valid) begin
                hold_chk = 1;
                hold_sk  = subkey;
                hold_rd  = subkey_round;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_key_ready();
        int n;
        n = 0;
        while (!key_ready && n < 50) begin
            tick();
            n++;
        end
        check("wait_key_ready", {63'd0, key_ready}, 64'd1);
    endtask

    // Runs handshakes until the scoreboard is empty; exits in the sched_done cycle
    task automatic drain(input bit rnd, input bit pulse, input bit hold_kv);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 400) begin
            subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pulse) key_valid = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (!hold_kv) key_valid = 1'b0;
        check("drain_left", 64'(sb.size()), 64'd0);
        sb.delete();
        check("done_pulse", {63'd0, sched_done}, 64'd1);
        check("done_key_ready", {63'd0, key_ready}, 64'd1);
    endtask

    task automatic run_sched(input vec_t v);
        key          = v.inv ? ~K0 : K0;
        decrypt      = v.dec;
        key_valid    = 1'b1;
        subkey_ready = 1'b1;
        wait_key_ready();
        push_sched(v.inv, v.dec);
        tick();
        // Key and decrypt are only sampled at the accept edge
        key_valid = 1'b0;
        key       = ~key;
        decrypt   = ~v.dec;
        check("first_valid", {63'd0, subkey_valid}, 64'd1);
        check("first_subkey", {16'd0, subkey}, {16'd0, exp_sub(v.inv, v.dec, 0)});
        check("first_round", {60'd0, subkey_round}, 64'd0);
        drain(v.rnd, v.pulse, 1'b0);
        subkey_ready = 1'b0;
        tick();
        check("done_drop", {63'd0, sched_done}, 64'd0);
        check("idle_held_subkey", {16'd0, subkey}, {16'd0, exp_sub(v.inv, v.dec, 15)});
    endtask

    initial begin
        vec_t vecs [6];
        int   n;
        vecs[0] = '{inv: 0, dec: 0, rnd: 0, pulse: 0};
        vecs[1] = '{inv: 0, dec: 0, rnd: 1, pulse: 0};
        vecs[2] = '{inv: 0, dec: 1, rnd: 0, pulse: 0};
        vecs[3] = '{inv: 1, dec: 0, rnd: 0, pulse: 0};
        vecs[4] = '{inv: 1, dec: 1, rnd: 1, pulse: 0};
        vecs[5] = '{inv: 0, dec: 0, rnd: 1, pulse: 1};

        reset        = 1'b1;
        key          = '0;
        key_valid    = 1'b0;
        decrypt      = 1'b0;
        subkey_ready = 1'b0;
        tick();
        tick();
        check("rst_key_ready", {63'd0, key_ready}, 64'd0);
        check("rst_valid", {63'd0, subkey_valid}, 64'd0);
        check("rst_subkey", {16'd0, subkey}, 64'd0);
        check("rst_round", {60'd0, subkey_round}, 64'd0);
        check("rst_done", {63'd0, sched_done}, 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_key_ready", {63'd0, key_ready}, 64'd1);
        tick();

        // Table-driven schedules
        foreach (vecs[i]) run_sched(vecs[i]);

        // Reset at round 7 abandons the schedule without sched_done
        key          = K0;
        decrypt      = 1'b0;
        key_valid    = 1'b1;
        subkey_ready = 1'b1;
        wait_key_ready();
        push_sched(1'b0, 1'b0);
        tick();
        key_valid = 1'b0;
        n = 0;
        while (subkey_round != 4'd7 && n < 40) begin
            tick();
            n++;
        end
        check("reach_round7", {60'd0, subkey_round}, 64'd7);
        reset = 1'b1;
        tick();
        sb.delete();
        check("midrst_valid", {63'd0, subkey_valid}, 64'd0);
        check("midrst_round", {60'd0, subkey_round}, 64'd0);
        check("midrst_done", {63'd0, sched_done}, 64'd0);
        check("midrst_key_ready", {63'd0, key_ready}, 64'd0);
        reset = 1'b0;
        #1;
        check("midrst_release_ready", {63'd0, key_ready}, 64'd1);
        tick();
        tick();
        run_sched(vecs[0]);

        // key_valid held with a second key: accepted in the sched_done cycle
        key          = K0;
        decrypt      = 1'b0;
        key_valid    = 1'b1;
        subkey_ready = 1'b1;
        wait_key_ready();
        push_sched(1'b0, 1'b0);
        tick();
        key = ~K0;
        drain(1'b0, 1'b0, 1'b1);
        push_sched(1'b1, 1'b0);
        tick();
        key_valid = 1'b0;
        check("b2b_valid", {63'd0, subkey_valid}, 64'd1);
        check("b2b_first", {16'd0, subkey}, {16'd0, ~KTAB[0]});
        drain(1'b0, 1'b0, 1'b0);
        subkey_ready = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
